// File: rtl/register_pkg.sv
// Shared definitions for the register write-back path: widths, the queued
// write entry, and the slot helper used when scanning entries by age.
package register_pkg;

  localparam int REG_COUNT = 16;
  localparam int SEL_W     = 4;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [SEL_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Slot holding the entry that is `age` positions older than the most
  // recently written one (age 0 = youngest). depth must be a power of two.
  function automatic int unsigned youngest_match(input int unsigned tail,
                                                 input int unsigned age,
                                                 input int unsigned depth);
    return (tail + depth - 1 - age) & (depth - 1);
  endfunction

endpackage

// File: rtl/register_writeback_buffer_if.sv
// Write-request channel from the execute/writeback stage into the buffer.
// Handshake: a request transfers on a rising edge where wr_valid && wr_ready;
// wr_ready depends only on buffer occupancy, never on wr_valid.
interface register_writeback_buffer_if #(
  parameter int SEL_W  = register_pkg::SEL_W,
  parameter int DATA_W = register_pkg::DATA_W
);
  logic              wr_valid;
  logic              wr_ready;
  logic [SEL_W-1:0]  wr_dest;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_dest, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_dest, input wr_data, output wr_ready);
endinterface

// File: rtl/wb_forward_mux.sv
// Combinational forwarding search: returns the data of the youngest queued
// entry whose destination matches sel_i, else the register file value.
module wb_forward_mux #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = register_pkg::DATA_W,
  parameter int SEL_W  = register_pkg::SEL_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [SEL_W-1:0]  dest_i [DEPTH],
  input  logic [DATA_W-1:0] data_i [DEPTH],
  input  logic [PTR_W-1:0]  tail_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o
);
  import register_pkg::*;

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the youngest match is the last one to land.
  always_comb begin
    data_o = rf_data_i;
    slot   = '0;
    for (int age = DEPTH - 1; age >= 0; age--) begin
      slot = PTR_W'(youngest_match(int'(tail_i), unsigned'(age), DEPTH));
      if ((CNT_W'(age) < count_i) && (dest_i[slot] == sel_i)) begin
        data_o = data_i[slot];
      end
    end
  end

endmodule

// File: rtl/register_writeback_buffer.sv
// Pending-write FIFO in front of register_file: accepts writes, drains one
// per cycle into the file, and forwards still-queued data onto the read ports.
module register_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = register_pkg::DATA_W,
  parameter int SEL_W  = register_pkg::SEL_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  register_writeback_buffer_if.slave wr,
  input  logic                 drain_hold,
  output logic [DATA_W-1:0]    port_c,
  output logic [SEL_W-1:0]     decoder_control,
  output logic                 load_enable,
  input  logic [SEL_W-1:0]     a_select,
  input  logic [SEL_W-1:0]     b_select,
  input  logic [DATA_W-1:0]    rf_port_a,
  input  logic [DATA_W-1:0]    rf_port_b,
  output logic [DATA_W-1:0]    port_a,
  output logic [DATA_W-1:0]    port_b,
  output logic [CNT_W-1:0]     pending_count
);
  import register_pkg::*;

  logic [SEL_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full buffer refuses writes even when the head drains this same cycle.
  assign push = wr.wr_valid && !full;
  assign pop  = !empty && !drain_hold;

  assign wr.wr_ready   = !full;
  assign pending_count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail_q] <= wr.wr_dest;
      data_q[tail_q] <= wr.wr_data;
    end
  end

  assign load_enable     = pop;
  assign port_c          = pop ? data_q[head_q] : '0;
  assign decoder_control = pop ? dest_q[head_q] : '0;

  wb_forward_mux #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_fwd_a (
    .dest_i    (dest_q),
    .data_i    (data_q),
    .tail_i    (tail_q),
    .count_i   (count_q),
    .sel_i     (a_select),
    .rf_data_i (rf_port_a),
    .data_o    (port_a)
  );

  wb_forward_mux #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_fwd_b (
    .dest_i    (dest_q),
    .data_i    (data_q),
    .tail_i    (tail_q),
    .count_i   (count_q),
    .sel_i     (b_select),
    .rf_data_i (rf_port_b),
    .data_o    (port_b)
  );

endmodule

// File: tb/tb_register_writeback_buffer.sv
// Directed bench for register_writeback_buffer with a small register file
// model; accepted writes are queued and matched against drained commits.
module tb_register_writeback_buffer;
  import register_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int E_W   = $bits(wb_entry_t);

  logic              clk;
  logic              reset;
  logic              drain_hold;
  logic [DATA_W-1:0] port_c;
  logic [SEL_W-1:0]  decoder_control;
  logic              load_enable;
  logic [SEL_W-1:0]  a_select, b_select;
  logic [DATA_W-1:0] rf_port_a, rf_port_b;
  logic [DATA_W-1:0] port_a, port_b;
  logic [CNT_W-1:0]  pending_count;

  register_writeback_buffer_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) wr_if ();

  register_writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr              (wr_if),
    .drain_hold      (drain_hold),
    .port_c          (port_c),
    .decoder_control (decoder_control),
    .load_enable     (load_enable),
    .a_select        (a_select),
    .b_select        (b_select),
    .rf_port_a       (rf_port_a),
    .rf_port_b       (rf_port_b),
    .port_a          (port_a),
    .port_b          (port_b),
    .pending_count   (pending_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register file model ----------------
  logic [DATA_W-1:0] rf [REG_COUNT];
  initial for (int i = 0; i < REG_COUNT; i++) rf[i] = '0;
  always @(posedge clk) if (load_enable) rf[decoder_control] <= port_c;
  assign rf_port_a = rf[a_select];
  assign rf_port_b = rf[b_select];

  // ---------------- scoreboard ----------------
  logic [E_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic streaming = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wb_entry_t e;
    if (!reset) begin
      if (load_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(load_enable), 64'd0);
        end else begin
          e = wb_entry_t'(exp_q.pop_front());
          check("commit_sel", 64'(decoder_control), 64'(e.dest));
          check("commit_data", 64'(port_c), 64'(e.data));
        end
      end else begin
        check("idle_port_c", 64'(port_c), 64'd0);
        check("idle_sel", 64'(decoder_control), 64'd0);
      end
      if (streaming) begin
        check("stream_ready", 64'(wr_if.wr_ready), 64'd1);
        check("stream_count_le1", 64'(pending_count > 1), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [SEL_W-1:0] d, input logic [DATA_W-1:0] v);
    int n = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_dest  = d;
    wr_if.wr_data  = v;
    @(negedge clk);
    while (!wr_if.wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (wr_if.wr_ready) exp_q.push_back(E_W'({d, v}));
    check("push_accept", 64'(wr_if.wr_ready), 64'd1);
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while (pending_count != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 64'(pending_count), 64'd0);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    drain_hold = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_dest  = '0;
    wr_if.wr_data  = '0;
    a_select = '0;
    b_select = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_load_enable", 64'(load_enable), 64'd0);
    check("rst_port_c", 64'(port_c), 64'd0);
    check("rst_sel", 64'(decoder_control), 64'd0);
    check("rst_pending", 64'(pending_count), 64'd0);
    check("rst_ready", 64'(wr_if.wr_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // 1: single write, one-cycle latency to commit
    do_push(4'd3, 32'h11);
    @(negedge clk);
    check("t1_load_enable", 64'(load_enable), 64'd1);
    check("t1_pending", 64'(pending_count), 64'd1);
    tick();
    a_select = 4'd3;
    @(negedge clk);
    check("t1_port_a", 64'(port_a), 64'h11);
    check("t1_load_enable_off", 64'(load_enable), 64'd0);
    check("t1_pending_zero", 64'(pending_count), 64'd0);
    tick();

    // 2: fill under hold, refuse fifth write, drain in order
    drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) do_push(SEL_W'(i), DATA_W'(i));
    wr_if.wr_valid = 1'b1;
    wr_if.wr_dest  = 4'd5;
    wr_if.wr_data  = 32'd5;
    @(negedge clk);
    check("t2_full_ready", 64'(wr_if.wr_ready), 64'd0);
    check("t2_full_count", 64'(pending_count), 64'd4);
    tick();
    @(negedge clk);
    check("t2_refused_count", 64'(pending_count), 64'd4);
    tick();
    drain_hold = 1'b0;
    do_push(4'd5, 32'd5);
    wait_empty();
    check("t2_rf1", 64'(rf[1]), 64'd1);
    check("t2_rf5", 64'(rf[5]), 64'd5);

    // 3: two pending writes to R10, youngest forwarded throughout
    drain_hold = 1'b1;
    do_push(4'd10, 32'd50);
    do_push(4'd10, 32'd60);
    a_select = 4'd10;
    @(negedge clk);
    check("t3_fwd_held", 64'(port_a), 64'd60);
    check("t3_pending2", 64'(pending_count), 64'd2);
    tick();
    drain_hold = 1'b0;
    @(negedge clk);
    check("t3_fwd_head_writing", 64'(port_a), 64'd60);
    tick();
    @(negedge clk);
    check("t3_fwd_after_first", 64'(port_a), 64'd60);
    check("t3_pending1", 64'(pending_count), 64'd1);
    tick();
    @(negedge clk);
    check("t3_port_a_final", 64'(port_a), 64'd60);
    check("t3_rf10", 64'(rf[10]), 64'd60);
    tick();

    // 4: streaming twelve writes back to back, pointers wrap three times
    streaming = 1'b1;
    for (int i = 0; i < 12; i++) do_push(SEL_W'(i), 32'h100 + DATA_W'(i));
    wait_empty();
    streaming = 1'b0;
    check("t4_rf0", 64'(rf[0]), 64'h100);
    check("t4_rf11", 64'(rf[11]), 64'h10b);

    // 5: reset discards queued writes
    drain_hold = 1'b1;
    do_push(4'd2, 32'd7);
    do_push(4'd5, 32'd9);
    do_push(4'd2, 32'd8);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    drain_hold = 1'b0;
    a_select = 4'd2;
    @(negedge clk);
    check("t5_load_enable", 64'(load_enable), 64'd0);
    check("t5_pending", 64'(pending_count), 64'd0);
    check("t5_ready", 64'(wr_if.wr_ready), 64'd1);
    check("t5_port_a_rf", 64'(port_a), 64'h102);
    repeat (3) tick();
    check("t5_rf2_kept", 64'(rf[2]), 64'h102);
    check("t5_rf5_kept", 64'(rf[5]), 64'h105);

    // 6: simultaneous forwarded and non-forwarded reads
    drain_hold = 1'b1;
    do_push(4'd5, 32'hAB);
    a_select = 4'd6;
    b_select = 4'd5;
    @(negedge clk);
    check("t6_port_b_fwd", 64'(port_b), 64'hAB);
    check("t6_port_a_rf", 64'(port_a), 64'h106);
    tick();
    drain_hold = 1'b0;
    wait_empty();
    check("t6_rf5", 64'(rf[5]), 64'hAB);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_writeback_buffer.md
Name: register_writeback_buffer

Overview:
- Write-side initiator for register_file.
- Accepts register write requests from the execute/writeback stage through a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Drains one write per cycle into register_file via port_c/decoder_control/load_enable.
- Forwards still-pending data onto the read ports so that readers never see stale register values.

Parameters:
- DEPTH, 4, number of pending-write FIFO entries (power of two, ≥2)
- DATA_W, 32, register width
- SEL_W, 4, register select width (16 registers)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  buffer can accept a write this cycle
- wr_dest  in  SEL_W  destination register number
- wr_data  in  DATA_W  value to write
- drain_hold  in  1  when 1, suppresses draining (pipeline stall / bench control)
- port_c  out  DATA_W  write data to register_file
- decoder_control  out  SEL_W  write register select to register_file
- load_enable  out  1  write strobe to register_file
- a_select  in  SEL_W  read select A (also routed to register_file)
- b_select  in  SEL_W  read select B (also routed to register_file)
- rf_port_a  in  DATA_W  register_file port_a
- rf_port_b  in  DATA_W  register_file port_b
- port_a  out  DATA_W  forwarded read A
- port_b  out  DATA_W  forwarded read B
- pending_count  out  clog2(DEPTH)+1  number of entries currently queued

Behaviour:
- Reset:
  - head, tail and count are cleared; FIFO is empty.
  - load_enable=0, port_c=0, decoder_control=0, pending_count=0, wr_ready=1.
  - Reset asserted mid-operation discards all queued writes; none reach register_file.
- Push:
  - Occurs on an edge where wr_valid && wr_ready.
  - Entry {wr_dest, wr_data} is written at tail; tail increments mod DEPTH.
- Ready:
  - wr_ready = !full. This is combinational from count only, with no dependence on wr_valid or on a same-cycle pop.
  - When full, a write is refused even if a pop occurs that cycle.
- Drain:
  - load_enable = !empty && !drain_hold (combinational).
  - While load_enable=1, port_c and decoder_control present the head entry. Otherwise both are 0.
  - register_file captures the write on the same edge on which the buffer pops head (head increments mod DEPTH).
- Latency: a write accepted at edge N on an empty buffer drives load_enable during cycle N→N+1 and is committed in register_file at edge N+1.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Ordering:
  - Writes commit strictly in acceptance order.
  - Multiple pending writes to the same register are all performed; the last one wins.
- Forwarding (combinational):
  - port_a = data of the youngest valid entry whose dest == a_select; if no entry matches, port_a = rf_port_a.
  - port_b uses the same rule with b_select.
  - The head entry being written in the current cycle is included in the search.
  - A write being pushed in the current cycle is NOT forwarded; it is visible from the next cycle.
- Pointers:
  - Width is clog2(DEPTH); wrap-around is natural modulo.
  - full = (count==DEPTH), empty = (count==0).
- No illegal states: pushes and pops are gated solely by full/empty.

Decomposition:
- Shared package register_pkg holds:
  - REG_COUNT=16, SEL_W=4, DATA_W=32;
  - typedef wb_entry_t {dest, data};
  - function youngest_match index helper.
- One natural sub-module, wb_forward_mux: a combinational priority search over FIFO entries (youngest-first, relative to tail), instantiated twice (A and B).
- The FIFO storage and pointer logic stay in the top module.

Test Plan:
1. Reset, then push R3=0x11 at cycle 1, drain_hold=0 → load_enable=1 with decoder_control=3, port_c=0x11 for exactly one cycle; a subsequent read with a_select=3 gives port_a=0x11 from rf_port_a; pending_count returns to 0.
2. drain_hold=1, push R1..R4 with values 1..4 → after 4 accepts wr_ready=0 and pending_count=4; a fifth push of R5=5 is not accepted. Release drain_hold → commits R1,R2,R3,R4 on consecutive edges, then R5 is accepted once wr_ready=1.
3. drain_hold=1, push R10=50 then R10=60; a_select=10 with rf_port_a=0 → port_a=60. Release hold → port_a=60 after the first commit and after the second; register_file ends with R10=60.
4. Continuous streaming of 12 pushes with drain_hold=0 → wr_ready stays 1, pointers wrap three times, commits arrive in order with no loss, and pending_count never exceeds 1.
5. drain_hold=1, three entries queued (R2=7, R5=9, R2=8), assert reset for one cycle → load_enable=0 and pending_count=0; no writes reach the file; port_a with a_select=2 equals rf_port_a.
6. b_select=5 with R5=0xAB pending and a_select=6 with nothing pending → port_b=0xAB and port_a=rf_port_a at the same time.
